multi_channel_timer: RTL and testbench

//  N-channel programmable tick/timer. Generalises the fixed single-count overflow timer.

---
 rtl/timer_pkg.sv | 27 ++
 rtl/timer_channel.sv | 92 +++++++++
 rtl/multi_channel_timer.sv | 75 +++++++
 tb/tb_multi_channel_timer.sv | 453 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared types for the multi-channel tick timer: channel FSM states and the
// per-channel configuration captured on start.
package timer_pkg;

    typedef enum logic {
        TMR_IDLE = 1'b0,
        TMR_RUN  = 1'b1
    } tmr_state_t;

    localparam int MAX_CH    = 16;
    // Widest counter a channel supports; config period is stored zero-extended to this.
    localparam int MAX_CNT_W = 32;

    typedef struct packed {
        logic                 one_shot;
        logic [MAX_CNT_W-1:0] period;
    } tmr_cfg_t;

    function automatic tmr_cfg_t make_cfg(input logic one_shot,
                                          input logic [MAX_CNT_W-1:0] period);
        tmr_cfg_t cfg;
        cfg.one_shot = one_shot;
        cfg.period   = period;
        return cfg;
    endfunction

endpackage

// File: rtl/timer_channel.sv
// One timer channel: IDLE/RUN FSM, up-counter to a latched terminal count,
// registered tick strobe, toggle and busy. Counting advances only when
// i_adv is high; start/stop act on every clock.
//
//  state    | meaning
//  TMR_IDLE | counter held at 0, busy low, waiting for start
//  TMR_RUN  | counting toward latched period, ticking at terminal count
module timer_channel
    import timer_pkg::*;
#(
    parameter int CNT_W = 25
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_adv,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic             i_one_shot,
    input  logic [CNT_W-1:0] i_period,
    output logic             o_tick,
    output logic             o_toggle,
    output logic             o_busy
);

    tmr_state_t       r_state;
    tmr_cfg_t         r_cfg;
    logic [CNT_W-1:0] r_cnt;
    logic             r_tick;
    logic             r_toggle;
    logic             r_busy;
    logic             w_at_tc;
    tmr_cfg_t         w_new_cfg;

    // Comparing at full width keeps P = 2^CNT_W-1 reachable without the counter wrapping first.
    assign w_at_tc   = (MAX_CNT_W'(r_cnt) == r_cfg.period);
    assign w_new_cfg = make_cfg(i_one_shot, MAX_CNT_W'(i_period));

    // Channel FSM with counter and registered outputs; stop beats start, start beats counting.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= TMR_IDLE;
            r_cfg    <= '0;
            r_cnt    <= '0;
            r_tick   <= 1'b0;
            r_toggle <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            case (r_state)
                TMR_IDLE: begin
                    r_cnt <= '0;
                    if (i_start && !i_stop) begin
                        r_cfg   <= w_new_cfg;
                        r_state <= TMR_RUN;
                        r_busy  <= 1'b1;
                    end
                end
                TMR_RUN: begin
                    if (i_stop) begin
                        r_state <= TMR_IDLE;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end else if (i_start) begin
                        r_cfg <= w_new_cfg;
                        r_cnt <= '0;
                    end else if (i_adv) begin
                        if (w_at_tc) begin
                            r_cnt    <= '0;
                            r_tick   <= 1'b1;
                            r_toggle <= ~r_toggle;
                            if (r_cfg.one_shot) begin
                                r_state <= TMR_IDLE;
                                r_busy  <= 1'b0;
                            end
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    r_state <= TMR_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_tick   = r_tick;
    assign o_toggle = r_toggle;
    assign o_busy   = r_busy;

endmodule

// File: rtl/multi_channel_timer.sv
// N-channel programmable tick timer. Each channel produces a 1-clk tick
// enable and a toggle square wave; consumers use tick as an enable only.
// Define TIMER_PRESCALER_EN to add a shared free-running prescaler that
// slows every channel's counting by PRESCALE_DIV; without it channels
// advance on every clock and PRESCALE_DIV has no effect.
module multi_channel_timer
    import timer_pkg::*;
#(
    parameter int NUM_CH       = 4,
    parameter int CNT_W        = 25,
    parameter int PRESCALE_DIV = 27
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       start,
    input  logic [NUM_CH-1:0]       stop,
    input  logic [NUM_CH-1:0]       one_shot,
    input  logic [NUM_CH*CNT_W-1:0] period,
    output logic [NUM_CH-1:0]       tick,
    output logic [NUM_CH-1:0]       toggle,
    output logic [NUM_CH-1:0]       busy
);

    logic w_adv;

    if (NUM_CH < 1 || NUM_CH > MAX_CH) begin : g_bad_num_ch
        $error("multi_channel_timer: NUM_CH out of range");
    end
    if (CNT_W < 1 || CNT_W > MAX_CNT_W) begin : g_bad_cnt_w
        $error("multi_channel_timer: CNT_W out of range");
    end
    if (PRESCALE_DIV < 1) begin : g_bad_div
        $error("multi_channel_timer: PRESCALE_DIV must be at least 1");
    end

`ifdef TIMER_PRESCALER_EN
    localparam int PRE_W = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;

    logic [PRE_W-1:0] r_pre;

    // The strobe is the wrap point, so the first advance after reset is DIV clocks in.
    assign w_adv = (r_pre == PRE_W'(PRESCALE_DIV - 1));

    // Free-running prescaler shared by all channels; never paused by channel activity.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pre <= '0;
        end else if (w_adv) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + PRE_W'(1);
        end
    end
`else
    assign w_adv = 1'b1;
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        timer_channel #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .i_adv      (w_adv),
            .i_start    (start[i]),
            .i_stop     (stop[i]),
            .i_one_shot (one_shot[i]),
            .i_period   (period[i*CNT_W +: CNT_W]),
            .o_tick     (tick[i]),
            .o_toggle   (toggle[i]),
            .o_busy     (busy[i])
        );
    end

endmodule

// File: tb/tb_multi_channel_timer.sv
// Testbench for multi_channel_timer. Expected ticks (channel, cycle, toggle
// level) are queued when stimulus is driven; a negedge monitor records the
// ticks the DUT produces and each test compares the two queues.
module tb_multi_channel_timer;

    localparam int NCH = 4;
    localparam int CW  = 4;
    localparam int DIV = 3;

    typedef struct packed {
        logic [7:0]  ch;
        logic [31:0] cyc;
        logic        tog;
    } ev_t;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic [NCH-1:0]      start = '0;
    logic [NCH-1:0]      stop = '0;
    logic [NCH-1:0]      one_shot = '0;
    logic [NCH*CW-1:0]   period = '0;
    logic [NCH-1:0]      tick;
    logic [NCH-1:0]      toggle;
    logic [NCH-1:0]      busy;

    int       cyc = 0;
    int       checks = 0;
    int       errors = 0;
    ev_t      exp_q[$];
    ev_t      obs_q[$];
    ev_t      mon_e;
    logic [NCH-1:0] tog_m = '0;

    multi_channel_timer #(
        .NUM_CH       (NCH),
        .CNT_W        (CW),
        .PRESCALE_DIV (DIV)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .stop     (stop),
        .one_shot (one_shot),
        .period   (period),
        .tick     (tick),
        .toggle   (toggle),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int c = 0; c < NCH; c++) begin
            if (tick[c] === 1'b1) begin
                mon_e.ch  = 8'(c);
                mon_e.cyc = 32'(cyc);
                mon_e.tog = toggle[c];
                obs_q.push_back(mon_e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_period(input int c, input int v);
        period[c*CW +: CW] = CW'(v);
    endtask

    function automatic void push_tick(input int c, input int at);
        ev_t ev;
        tog_m[c] = ~tog_m[c];
        ev.ch  = 8'(c);
        ev.cyc = 32'(at);
        ev.tog = tog_m[c];
        exp_q.push_back(ev);
    endfunction

    task automatic test_reset;
        ev_t o, e;
        reset = 1'b1;
        step(3);
        checks++;
        if ({tick, toggle, busy} !== '0) begin
            errors++;
            $display("FAIL reset_init got %b want 0", {tick, toggle, busy});
        end
        reset = 1'b0;
        set_period(0, 5);
        one_shot[0] = 1'b0;
        start[0] = 1'b1;
        step(1);
        start[0] = 1'b0;
        step(3);
        checks++;
        if (busy[0] !== 1'b1) begin
            errors++;
            $display("FAIL reset_busy_pre got %b want 1", busy[0]);
        end
        reset = 1'b1;
        step(1);
        checks++;
        if ({tick, toggle, busy} !== '0) begin
            errors++;
            $display("FAIL reset_mid got %b want 0", {tick, toggle, busy});
        end
        step(2);
        reset = 1'b0;
        tog_m = '0;
        step(15);
        checks++;
        if (busy !== '0) begin
            errors++;
            $display("FAIL reset_busy_post got %b want 0", busy);
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL reset_count got %0d ticks want %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL reset_tick got ch%0d cyc%0d tog%0b want ch%0d cyc%0d tog%0b",
                         o.ch, o.cyc, o.tog, e.ch, e.cyc, e.tog);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_periodic;
        ev_t o, e;
        int  e0;
        set_period(0, 3);
        one_shot[0] = 1'b0;
        start[0] = 1'b1;
        e0 = cyc + 1;
        push_tick(0, e0 + 4);
        push_tick(0, e0 + 8);
        push_tick(0, e0 + 12);
        step(1);
        start[0] = 1'b0;
        for (int k = 0; k < 13; k++) begin
            step(1);
            checks++;
            if (busy[0] !== 1'b1) begin
                errors++;
                $display("FAIL periodic_busy cyc %0d got %b want 1", cyc, busy[0]);
            end
        end
        stop[0] = 1'b1;
        step(1);
        stop[0] = 1'b0;
        checks++;
        if (busy[0] !== 1'b0 || toggle[0] !== tog_m[0]) begin
            errors++;
            $display("FAIL periodic_stop got busy %b tog %b want busy 0 tog %b",
                     busy[0], toggle[0], tog_m[0]);
        end
        step(6);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL periodic_count got %0d ticks want %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL periodic_tick got ch%0d cyc%0d tog%0b want ch%0d cyc%0d tog%0b",
                         o.ch, o.cyc, o.tog, e.ch, e.cyc, e.tog);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_one_shot;
        ev_t o, e;
        int  e0;
        set_period(1, 0);
        one_shot[1] = 1'b1;
        start[1] = 1'b1;
        e0 = cyc + 1;
        push_tick(1, e0 + 1);
        step(1);
        start[1] = 1'b0;
        checks++;
        if (busy[1] !== 1'b1 || tick[1] !== 1'b0) begin
            errors++;
            $display("FAIL oneshot_first got busy %b tick %b want busy 1 tick 0", busy[1], tick[1]);
        end
        step(1);
        checks++;
        if (busy[1] !== 1'b0 || tick[1] !== 1'b1) begin
            errors++;
            $display("FAIL oneshot_tick got busy %b tick %b want busy 0 tick 1", busy[1], tick[1]);
        end
        step(8);
        checks++;
        if (busy[1] !== 1'b0) begin
            errors++;
            $display("FAIL oneshot_idle got busy %b want 0", busy[1]);
        end
        // P=0 periodic holds tick high every clock until stopped
        one_shot[1] = 1'b0;
        start[1] = 1'b1;
        e0 = cyc + 1;
        for (int k = 1; k <= 5; k++) push_tick(1, e0 + k);
        step(1);
        start[1] = 1'b0;
        step(5);
        stop[1] = 1'b1;
        step(1);
        stop[1] = 1'b0;
        checks++;
        if (tick[1] !== 1'b0 || busy[1] !== 1'b0) begin
            errors++;
            $display("FAIL p0_stop got tick %b busy %b want 0 0", tick[1], busy[1]);
        end
        step(5);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL oneshot_count got %0d ticks want %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL oneshot_tick got ch%0d cyc%0d tog%0b want ch%0d cyc%0d tog%0b",
                         o.ch, o.cyc, o.tog, e.ch, e.cyc, e.tog);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_stop;
        ev_t o, e;
        int  e0;
        set_period(2, 9);
        one_shot[2] = 1'b0;
        start[2] = 1'b1;
        e0 = cyc + 1;
        push_tick(2, e0 + 10);
        step(1);
        start[2] = 1'b0;
        step(17);
        stop[2] = 1'b1;
        step(1);
        stop[2] = 1'b0;
        checks++;
        if (busy[2] !== 1'b0 || toggle[2] !== tog_m[2]) begin
            errors++;
            $display("FAIL stop_hold got busy %b tog %b want busy 0 tog %b",
                     busy[2], toggle[2], tog_m[2]);
        end
        step(10);
        start[2] = 1'b1;
        stop[2] = 1'b1;
        step(1);
        start[2] = 1'b0;
        stop[2] = 1'b0;
        checks++;
        if (busy[2] !== 1'b0) begin
            errors++;
            $display("FAIL stop_wins got busy %b want 0", busy[2]);
        end
        step(15);
        checks++;
        if (busy[2] !== 1'b0) begin
            errors++;
            $display("FAIL stop_wins_late got busy %b want 0", busy[2]);
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL stop_count got %0d ticks want %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL stop_tick got ch%0d cyc%0d tog%0b want ch%0d cyc%0d tog%0b",
                         o.ch, o.cyc, o.tog, e.ch, e.cyc, e.tog);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_restart;
        ev_t o, e;
        int  e0;
        set_period(3, 4);
        one_shot[3] = 1'b0;
        start[3] = 1'b1;
        e0 = cyc + 1;
        step(1);
        start[3] = 1'b0;
        step(4);
        start[3] = 1'b1;
        step(1);
        start[3] = 1'b0;
        set_period(3, 9);
        push_tick(3, e0 + 10);
        push_tick(3, e0 + 15);
        push_tick(3, e0 + 20);
        step(16);
        stop[3] = 1'b1;
        step(1);
        stop[3] = 1'b0;
        step(8);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL restart_count got %0d ticks want %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL restart_tick got ch%0d cyc%0d tog%0b want ch%0d cyc%0d tog%0b",
                         o.ch, o.cyc, o.tog, e.ch, e.cyc, e.tog);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_back_to_back;
        ev_t o, e;
        int  e0;
        // Maximum period on every channel at once, all ticking together
        for (int c = 0; c < NCH; c++) set_period(c, (1 << CW) - 1);
        one_shot = '0;
        start = '1;
        e0 = cyc + 1;
        for (int k = 1; k <= 2; k++)
            for (int c = 0; c < NCH; c++) push_tick(c, e0 + 16 * k);
        step(1);
        start = '0;
        step(32);
        stop = '1;
        step(1);
        stop = '0;
        checks++;
        if (busy !== '0) begin
            errors++;
            $display("FAIL b2b_busy got %b want 0", busy);
        end
        step(5);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL b2b_count got %0d ticks want %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL b2b_tick got ch%0d cyc%0d tog%0b want ch%0d cyc%0d tog%0b",
                         o.ch, o.cyc, o.tog, e.ch, e.cyc, e.tog);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_prescaler;
        ev_t o;
        int  e0;
        int  first;
        logic etog;
        for (int c = 0; c < NCH; c++) set_period(c, 1);
        one_shot = '0;
        start = '1;
        e0 = cyc + 1;
        step(1);
        start = '0;
        step(20);
        stop = '1;
        step(1);
        stop = '0;
        step(4);
        checks++;
        if (obs_q.size() != 3 * NCH) begin
            errors++;
            $display("FAIL pre_count got %0d ticks want %0d", obs_q.size(), 3 * NCH);
        end else begin
            first = int'(obs_q[0].cyc);
            checks++;
            if (first < e0 + DIV + 1 || first > e0 + 2 * DIV) begin
                errors++;
                $display("FAIL pre_first got %0d want %0d..%0d", first - e0, DIV + 1, 2 * DIV);
            end
            for (int i = 0; i < 3; i++) begin
                for (int c = 0; c < NCH; c++) begin
                    o = obs_q[i * NCH + c];
                    etog = ((i % 2) == 0) ? ~tog_m[c] : tog_m[c];
                    checks++;
                    if (o.ch !== 8'(c) || o.cyc !== 32'(first + 2 * DIV * i) || o.tog !== etog) begin
                        errors++;
                        $display("FAIL pre_tick got ch%0d cyc%0d tog%0b want ch%0d cyc%0d tog%0b",
                                 o.ch, o.cyc, o.tog, c, first + 2 * DIV * i, etog);
                    end
                end
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        test_reset();
`ifdef TIMER_PRESCALER_EN
        test_prescaler();
`else
        test_periodic();
        test_one_shot();
        test_stop();
        test_restart();
        test_back_to_back();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
